rtc_bus_responder: RTL and testbench
====================================

# rtc_bus_responder

Synthesizable responder for the RTC's multiplexed parallel bus: the chip-side end of the CS/WR/RD/AD protocol that our bus controller drives. It samples the strobes and the 8-bit address/data bus and latches an address on the address phase. In the data phase it commits a write to, or serves a read from, a small byte register file. It stands in for the physical RTC in on-board loopback tests and system simulation. The register file also has a local update port for the time-keeping logic.

## Interface
- ADDR_W, 4 — register-file index width; 2**ADDR_W byte registers.
- TIMEOUT, 63 — maximum cycles allowed between address latch and data-phase start.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- CS, WR, RD, AD  in  1 each  bus strobes. CS/WR/RD are active low. AD low = address phase, AD high = data phase.
- dat_in  in  8  bus value seen by the responder.
- dat_out  out  8  read data driven onto the bus.
- dat_oe  out  1  tristate enable for dat_out.
- upd_en  in  1  local register write strobe.
- upd_addr  in  ADDR_W  local write index.
- upd_data  in  8  local write data.
- xfer_done  out  1  one-cycle pulse when a data phase completes.
- xfer_wr  out  1  valid with xfer_done: 1 = write, 0 = read.
- proto_err  out  1  one-cycle pulse on a protocol violation.

## Operation
- **Input synchronization:** CS, WR, RD, AD and dat_in pass through a 2-flop synchronizer. Strobe synchronizers reset to 1; the data synchronizer resets to 0. All logic uses the synchronized signals (s_*) and their one-cycle-delayed copies (p_*).
- **WR rise:** detected when p_WR=0 and s_WR=1. The qualifiers are p_CS and p_AD, i.e. sampled while WR was still low. The bus controller raises CS and WR together, so this sampling point is required.
- **FSM states:**
  - IDLE: on WR rise with p_CS=0, p_AD=0, latch addr=p_dat (8 bits) and go to ADDR_OK.
  - ADDR_OK:
    - WR rise with p_CS=0, p_AD=0 re-latches the address and stays in ADDR_OK.
    - WR rise with p_CS=0, p_AD=1 commits the write (see below), pulses xfer_done with xfer_wr=1, and goes to IDLE.
    - s_CS=0, s_RD=0, s_AD=1 goes to READING.
    - Wait counter reaching TIMEOUT raises proto_err and goes to IDLE.
  - READING: dat_oe=1 and dat_out=reg[addr]. When s_RD=1 or s_CS=1, go to IDLE, dat_oe=0, and pulse xfer_done with xfer_wr=0.
- **Write commit:** reg[addr] is written with p_dat.
- **Address range:** addr ≥ 2**ADDR_W is out of range. An out-of-range write is discarded and raises proto_err. An out-of-range read drives 0x00 and raises proto_err on entry to READING.
- **proto_err also pulses on:**
  - s_RD=0 and s_WR=0 together while s_CS=0; the FSM goes to IDLE.
  - A data-phase WR rise or RD fall while in IDLE (no address latched); no register change.
  - s_RD=0 while s_AD=0 and s_CS=0.
- **Update port:** upd_en writes reg[upd_addr]=upd_data at the clock edge.
  - A bus write to the same index in the same cycle wins.
  - A bus write to a different index in the same cycle: both take effect.

## Timing
- **Reset values:** every output is 0, every register-file byte is 0x00, the FSM is in IDLE, addr=0x00 and the wait counter is 0.
- **Pin to internal view:** 2 cycles.
- **Write:** the register updates on the 3rd rising edge after the WR pin rises. xfer_done pulses in that same cycle.
- **Read:** dat_oe and valid dat_out are registered outputs. They are asserted 3 cycles after the later of the CS and RD pin falls, and released 3 cycles after the earlier pin rise.
- **dat_out while dat_oe=0:** held at 0x00.
- **Wait counter:** cleared on entry to ADDR_OK, saturates, and is compared for equality with TIMEOUT.
- **Bus-controller compatibility:** the controller's 6-cycle strobe pulses, 12-cycle gap and AD held low 2 cycles past CS rise must yield a clean address latch and data phase.

## Structure
- Shared package holds the FSM state encoding (IDLE, ADDR_OK, READING), the register-count localparam derived from ADDR_W, and the RTC register index constants (seconds, minutes, hours, day, date, month, year, control), shared with the bus controller's write/read sequencers.
- One natural sub-module: bus_sync, the 2-flop synchronizer plus p_* delay and edge-detect outputs for the strobes and dat_in.

## Test plan
- Address 0x02 then write data 0x45 using controller-shaped timing → reg[2]=0x45; one xfer_done with xfer_wr=1; proto_err stays 0.
- Preload reg[5]=0x31 via upd_en, address 0x05, then RD low for 6 cycles → dat_oe high for 6 cycles with dat_out=0x31; xfer_done with xfer_wr=0 after release.
- Data-phase write of 0x99 with no preceding address → proto_err pulse; all registers unchanged.
- Address 0x03, then 70 idle cycles (TIMEOUT=63), then data write → proto_err at timeout; the later write gets a second proto_err and reg[3] is unchanged.
- Same-cycle bus write 0x10 and upd_en write 0x20 to index 1 → reg[1]=0x10. Same-cycle bus write to index 1 and upd_en to index 4 → both written.
- Reset asserted mid-READING → dat_oe=0 immediately, FSM in IDLE, registers 0x00; a subsequent full transaction succeeds.

Source files
------------

// File: rtl/rtc_bus_responder_pkg.sv
// Shared definitions for the RTC bus responder and the bus controller's sequencers.
// Holds the FSM encoding, the register-file sizing and the RTC register map.
package rtc_bus_responder_pkg;

    localparam int RTC_ADDR_W   = 4;
    localparam int RTC_NUM_REGS = 2 ** RTC_ADDR_W;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ADDR_OK = 2'd1,
        READING = 2'd2
    } rtc_state_t;

    localparam logic [7:0] REG_SECONDS = 8'h00;
    localparam logic [7:0] REG_MINUTES = 8'h01;
    localparam logic [7:0] REG_HOURS   = 8'h02;
    localparam logic [7:0] REG_DAY     = 8'h03;
    localparam logic [7:0] REG_DATE    = 8'h04;
    localparam logic [7:0] REG_MONTH   = 8'h05;
    localparam logic [7:0] REG_YEAR    = 8'h06;
    localparam logic [7:0] REG_CONTROL = 8'h07;

endpackage

// File: rtl/rtc_bus_responder_bus_sync.sv
// Two-flop synchronizer for the bus strobes and data, plus a one-cycle-delayed
// copy used for edge detection and for sampling qualifiers just before an edge.
module rtc_bus_responder_bus_sync (
    input  logic       clk,
    input  logic       reset,
    input  logic       cs,
    input  logic       wr,
    input  logic       rd,
    input  logic       ad,
    input  logic [7:0] dat,
    output logic       s_cs,
    output logic       s_wr,
    output logic       s_rd,
    output logic       s_ad,
    output logic       p_cs,
    output logic       p_ad,
    output logic [7:0] p_dat,
    output logic       wr_rise,
    output logic       rd_fall
);

    // strobe vectors are ordered {cs, wr, rd, ad}; strobes idle high
    logic [3:0] strb_meta, strb_s, strb_p;
    logic [7:0] dat_meta, dat_s;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            strb_meta <= '1;
            strb_s    <= '1;
            strb_p    <= '1;
            dat_meta  <= '0;
            dat_s     <= '0;
            p_dat     <= '0;
        end else begin
            strb_meta <= {cs, wr, rd, ad};
            strb_s    <= strb_meta;
            strb_p    <= strb_s;
            dat_meta  <= dat;
            dat_s     <= dat_meta;
            p_dat     <= dat_s;
        end
    end

    assign s_cs    = strb_s[3];
    assign s_wr    = strb_s[2];
    assign s_rd    = strb_s[1];
    assign s_ad    = strb_s[0];
    assign p_cs    = strb_p[3];
    assign p_ad    = strb_p[0];
    assign wr_rise = !strb_p[2] && strb_s[2];
    assign rd_fall = strb_p[1] && !strb_s[1];

endmodule

// File: rtl/rtc_bus_responder.sv
// Chip-side responder for the RTC CS/WR/RD/AD multiplexed bus with a byte
// register file and a local update port for the time-keeping logic.
//
//   state   | meaning
//   IDLE    | no address latched
//   ADDR_OK | address latched, waiting for a data phase (timed)
//   READING | driving reg[addr] onto the bus until RD or CS rises
module rtc_bus_responder
    import rtc_bus_responder_pkg::*;
#(
    parameter int ADDR_W  = RTC_ADDR_W,
    parameter int TIMEOUT = 63
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              CS,
    input  logic              WR,
    input  logic              RD,
    input  logic              AD,
    input  logic [7:0]        dat_in,
    output logic [7:0]        dat_out,
    output logic              dat_oe,
    input  logic              upd_en,
    input  logic [ADDR_W-1:0] upd_addr,
    input  logic [7:0]        upd_data,
    output logic              xfer_done,
    output logic              xfer_wr,
    output logic              proto_err
);

    localparam int              NUM_REGS = 2 ** ADDR_W;
    localparam int              CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic s_cs, s_wr, s_rd, s_ad, p_cs, p_ad, wr_rise, rd_fall;
    logic [7:0] p_dat;

    rtc_bus_responder_bus_sync u_sync (
        .clk     (clk),
        .reset   (reset),
        .cs      (CS),
        .wr      (WR),
        .rd      (RD),
        .ad      (AD),
        .dat     (dat_in),
        .s_cs    (s_cs),
        .s_wr    (s_wr),
        .s_rd    (s_rd),
        .s_ad    (s_ad),
        .p_cs    (p_cs),
        .p_ad    (p_ad),
        .p_dat   (p_dat),
        .wr_rise (wr_rise),
        .rd_fall (rd_fall)
    );

    rtc_state_t        state, nxt_state;
    logic [7:0]        addr;
    logic [ADDR_W-1:0] addr_idx;
    logic              in_range;
    logic [CNT_W-1:0]  wait_cnt;
    logic [7:0]        regs [NUM_REGS];

    logic addr_ld, bus_wr, cnt_clr, err_c, done_c, done_wr_c;
    logic both_low, both_low_q, rd_in_addr, rd_in_addr_q;

    assign addr_idx = addr[ADDR_W-1:0];
    assign in_range = (addr >> ADDR_W) == 8'd0;

    // level violations are reported once, on the cycle they first appear
    assign both_low   = !s_cs && !s_rd && !s_wr;
    assign rd_in_addr = !s_cs && !s_rd && !s_ad;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= nxt_state;
    end

    always_comb begin
        nxt_state = state;
        addr_ld   = 1'b0;
        bus_wr    = 1'b0;
        cnt_clr   = 1'b0;
        err_c     = (rd_in_addr && !rd_in_addr_q) || (both_low && !both_low_q);
        done_c    = 1'b0;
        done_wr_c = 1'b0;
        if (both_low) begin
            nxt_state = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (wr_rise && !p_cs && !p_ad) begin
                        addr_ld   = 1'b1;
                        cnt_clr   = 1'b1;
                        nxt_state = ADDR_OK;
                    end else if (wr_rise && !p_cs && p_ad) begin
                        err_c = 1'b1;
                    end else if (rd_fall && !s_cs && s_ad) begin
                        err_c = 1'b1;
                    end
                end
                ADDR_OK: begin
                    if (wr_rise && !p_cs && !p_ad) begin
                        addr_ld = 1'b1;
                        cnt_clr = 1'b1;
                    end else if (wr_rise && !p_cs && p_ad) begin
                        nxt_state = IDLE;
                        if (in_range) begin
                            bus_wr    = 1'b1;
                            done_c    = 1'b1;
                            done_wr_c = 1'b1;
                        end else begin
                            err_c = 1'b1;
                        end
                    end else if (!s_cs && !s_rd && s_ad) begin
                        nxt_state = READING;
                        if (!in_range) err_c = 1'b1;
                    end else if (wait_cnt == CNT_W'(TIMEOUT)) begin
                        err_c     = 1'b1;
                        nxt_state = IDLE;
                    end
                end
                READING: begin
                    if (s_rd || s_cs) begin
                        nxt_state = IDLE;
                        done_c    = 1'b1;
                    end
                end
                default: nxt_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr         <= '0;
            wait_cnt     <= '0;
            proto_err    <= 1'b0;
            xfer_done    <= 1'b0;
            xfer_wr      <= 1'b0;
            dat_oe       <= 1'b0;
            dat_out      <= '0;
            both_low_q   <= 1'b0;
            rd_in_addr_q <= 1'b0;
        end else begin
            if (addr_ld) addr <= p_dat;
            if (cnt_clr)
                wait_cnt <= '0;
            else if (state == ADDR_OK && wait_cnt != CNT_MAX)
                wait_cnt <= wait_cnt + 1'b1;
            proto_err    <= err_c;
            xfer_done    <= done_c;
            xfer_wr      <= done_wr_c;
            dat_oe       <= (nxt_state == READING);
            dat_out      <= (nxt_state == READING && in_range) ? regs[addr_idx] : 8'h00;
            both_low_q   <= both_low;
            rd_in_addr_q <= rd_in_addr;
        end
    end

    // the bus write is assigned last so it wins over a same-index update
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= 8'h00;
        end else begin
            if (upd_en) regs[upd_addr] <= upd_data;
            if (bus_wr) regs[addr_idx] <= p_dat;
        end
    end

endmodule

// File: tb/tb_rtc_bus_responder.sv
// Scoreboard bench for rtc_bus_responder: stimulus queues expected bus events,
// an independent monitor compares them as the responder reports completions/errors.
module tb_rtc_bus_responder;
    import rtc_bus_responder_pkg::*;

    localparam int K_WR  = 0;
    localparam int K_RD  = 1;
    localparam int K_ERR = 2;

    typedef struct {
        int         kind;
        logic [7:0] data;
        int         len;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       CS = 1'b1, WR = 1'b1, RD = 1'b1, AD = 1'b1;
    logic [7:0] dat_in = 8'h00;
    logic [7:0] dat_out;
    logic       dat_oe;
    logic       upd_en = 1'b0;
    logic [3:0] upd_addr = 4'h0;
    logic [7:0] upd_data = 8'h00;
    logic       xfer_done, xfer_wr, proto_err;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    int         oe_len = 0;
    logic [7:0] rd_data = 8'h00;
    logic       rd_stable = 1'b1;

    rtc_bus_responder #(.ADDR_W(4), .TIMEOUT(63)) dut (
        .clk       (clk),
        .reset     (reset),
        .CS        (CS),
        .WR        (WR),
        .RD        (RD),
        .AD        (AD),
        .dat_in    (dat_in),
        .dat_out   (dat_out),
        .dat_oe    (dat_oe),
        .upd_en    (upd_en),
        .upd_addr  (upd_addr),
        .upd_data  (upd_data),
        .xfer_done (xfer_done),
        .xfer_wr   (xfer_wr),
        .proto_err (proto_err)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog expired got running want finished");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int k, input logic [7:0] d, input int l);
        exp_t e;
        e.kind = k;
        e.data = d;
        e.len  = l;
        sb.push_back(e);
    endtask

    task automatic bus_addr(input logic [7:0] a);
        AD = 1'b0; dat_in = a; CS = 1'b0; WR = 1'b0;
        cyc(6);
        CS = 1'b1; WR = 1'b1;
        cyc(2);
        AD = 1'b1;
        cyc(10);
    endtask

    task automatic bus_wdata(input logic [7:0] d);
        AD = 1'b1; dat_in = d; CS = 1'b0; WR = 1'b0;
        cyc(6);
        CS = 1'b1; WR = 1'b1;
        cyc(12);
    endtask

    // data-phase write with an update-port write landing on the same commit edge
    task automatic bus_wdata_upd(input logic [7:0] d, input logic [3:0] ua, input logic [7:0] ud);
        AD = 1'b1; dat_in = d; CS = 1'b0; WR = 1'b0;
        cyc(6);
        CS = 1'b1; WR = 1'b1;
        cyc(2);
        upd_en = 1'b1; upd_addr = ua; upd_data = ud;
        cyc(1);
        upd_en = 1'b0;
        cyc(9);
    endtask

    task automatic bus_read(input int n);
        AD = 1'b1; CS = 1'b0; RD = 1'b0;
        cyc(n);
        CS = 1'b1; RD = 1'b1;
        cyc(12);
    endtask

    task automatic write_reg(input logic [7:0] a, input logic [7:0] d);
        push(K_WR, 8'h00, 0);
        bus_addr(a);
        bus_wdata(d);
    endtask

    task automatic read_reg(input logic [7:0] a, input logic [7:0] d);
        push(K_RD, d, 6);
        bus_addr(a);
        bus_read(6);
    endtask

    task automatic upd(input logic [3:0] a, input logic [7:0] d);
        upd_en = 1'b1; upd_addr = a; upd_data = d;
        cyc(1);
        upd_en = 1'b0;
    endtask

    task automatic check_event(input int kind);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event got kind %0d want none", kind);
            return;
        end
        e = sb.pop_front();
        if (e.kind != kind) begin
            errors++;
            $display("FAIL event_kind got %0d want %0d", kind, e.kind);
        end else if (kind == K_RD) begin
            checks++;
            if (rd_data !== e.data || !rd_stable) begin
                errors++;
                $display("FAIL read_data got %02h stable %0b want %02h", rd_data, rd_stable, e.data);
            end
            checks++;
            if (oe_len != e.len) begin
                errors++;
                $display("FAIL read_oe_len got %0d want %0d", oe_len, e.len);
            end
            checks++;
            if (dat_out !== 8'h00) begin
                errors++;
                $display("FAIL idle_dat_out got %02h want 00", dat_out);
            end
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            oe_len = 0;
        end else begin
            if (proto_err) check_event(K_ERR);
            if (xfer_done) begin
                check_event(xfer_wr ? K_WR : K_RD);
                oe_len = 0;
            end
            if (dat_oe) begin
                if (oe_len == 0) begin
                    rd_data   = dat_out;
                    rd_stable = 1'b1;
                end else if (dat_out !== rd_data) begin
                    rd_stable = 1'b0;
                end
                oe_len++;
            end
        end
    end

    initial begin
        int wait_cnt;
        cyc(3);
        checks++;
        if ({dat_out, dat_oe, xfer_done, xfer_wr, proto_err} !== 12'h000) begin
            errors++;
            $display("FAIL reset_outputs got %03h want 000",
                     {dat_out, dat_oe, xfer_done, xfer_wr, proto_err});
        end
        reset = 1'b0;
        cyc(2);

        // basic write then read-back
        write_reg(REG_HOURS, 8'h45);
        read_reg(REG_HOURS, 8'h45);

        // preload through update port, read over the bus
        upd(REG_MONTH[3:0], 8'h31);
        read_reg(REG_MONTH, 8'h31);

        // data phase with no address
        push(K_ERR, 8'h00, 0);
        bus_wdata(8'h99);
        read_reg(REG_SECONDS, 8'h00);
        read_reg(REG_HOURS, 8'h45);

        // address then timeout, then a stray data write
        push(K_ERR, 8'h00, 0);
        bus_addr(REG_DAY);
        cyc(70);
        push(K_ERR, 8'h00, 0);
        bus_wdata(8'h77);
        read_reg(REG_DAY, 8'h00);

        // same-cycle bus and update writes
        push(K_WR, 8'h00, 0);
        bus_addr(REG_MINUTES);
        bus_wdata_upd(8'h10, REG_MINUTES[3:0], 8'h20);
        read_reg(REG_MINUTES, 8'h10);
        push(K_WR, 8'h00, 0);
        bus_addr(REG_MINUTES);
        bus_wdata_upd(8'h55, REG_DATE[3:0], 8'h66);
        read_reg(REG_MINUTES, 8'h55);
        read_reg(REG_DATE, 8'h66);

        // address range boundary
        write_reg(8'h0F, 8'h3C);
        read_reg(8'h0F, 8'h3C);
        push(K_ERR, 8'h00, 0);
        bus_addr(8'(RTC_NUM_REGS));
        bus_wdata(8'hEE);
        read_reg(REG_SECONDS, 8'h00);
        push(K_ERR, 8'h00, 0);
        push(K_RD, 8'h00, 6);
        bus_addr(8'h10);
        bus_read(6);

        // reset in the middle of a read
        bus_addr(REG_HOURS);
        AD = 1'b1; CS = 1'b0; RD = 1'b0;
        cyc(5);
        checks++;
        if (dat_oe !== 1'b1 || dat_out !== 8'h45) begin
            errors++;
            $display("FAIL pre_reset_read got oe %0b dat %02h want oe 1 dat 45", dat_oe, dat_out);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (dat_oe !== 1'b0 || dat_out !== 8'h00 || xfer_done !== 1'b0) begin
            errors++;
            $display("FAIL mid_read_reset got oe %0b dat %02h done %0b want 0 00 0",
                     dat_oe, dat_out, xfer_done);
        end
        CS = 1'b1; RD = 1'b1;
        cyc(2);
        reset = 1'b0;
        cyc(2);
        push(K_ERR, 8'h00, 0);
        bus_wdata(8'h12);
        read_reg(REG_HOURS, 8'h00);
        read_reg(REG_MONTH, 8'h00);
        write_reg(REG_CONTROL, 8'hA5);
        read_reg(REG_CONTROL, 8'hA5);

        wait_cnt = 0;
        while (sb.size() != 0 && wait_cnt < 100) begin
            cyc(1);
            wait_cnt++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
